braun_mult_seq: RTL



---
 rtl/braun_pkg.sv | 7 +
 rtl/braun_row.sv | 17 +
 rtl/braun_mult_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/braun_pkg.sv
// braun_pkg: shared state encoding and sizing helper for the sequential Braun multiplier.
package braun_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/braun_row.sv
// braun_row: one WIDTH-bit ripple-carry row of full adders, reused for every partial-product row.
module braun_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign co_o = c[WIDTH];
endmodule

// File: rtl/braun_mult_seq.sv
// braun_mult_seq: sign-magnitude shift-add multiplier, one Braun row per clock, valid/ready on both sides.
module braun_mult_seq
  import braun_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_row, p_q, p_d;
  logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d, addend, sum;
  logic neg_q, neg_d, co;
  assign addend = mb_q[0] ? ma_q : '0;
  braun_row #(.WIDTH(WIDTH)) u_row (
    .a_i  (acc_q[2*WIDTH-1:WIDTH]),
    .b_i  (addend),
    .sum_o(sum),
    .co_o (co)
  );
  // Row carry lands in the top bit as the accumulator shifts right.
  assign acc_row = {co, sum, acc_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    p_d     = p_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ma_d    = (signed_mode & a[WIDTH-1]) ? -a : a;
        mb_d    = (signed_mode & b[WIDTH-1]) ? -b : b;
        neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = CALC;
      end
      CALC: begin
        acc_d = acc_row;
        mb_d  = mb_q >> 1;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          p_d     = neg_q ? -acc_row : acc_row;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;
endmodule
